// File: rtl/nonce_collector.sv
// nonce_collector: queues 64-bit nonces from the core result bus in a small
// FIFO and drains each one as an 8-byte little-endian valid/ready stream.
// Ports: clk, rst (sync, active-low), nonce_bus/nonce_bus_wr (capture),
//   flush (new-job clear), tx_data/tx_valid/tx_ready (byte stream out),
//   count (FIFO occupancy, excludes shifter), overflow (sticky drop flag).
// Option: define NONCE_SYNC_EN to prefix every frame with a 0xA5 sync byte.
module nonce_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      nonce_bus,
    input  logic             nonce_bus_wr,
    input  logic             flush,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_SEND
    } state_t;

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    state_t           state_q, state_d;
    logic [63:0]      shift_q, shift_d;
    logic [2:0]       idx_q, idx_d;
    logic             push, pop;

    // Full test uses the registered count, so a pop in the same cycle
    // does not make room for the incoming nonce.
    assign push = nonce_bus_wr && (cnt_q != FULL) && !flush;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        pop      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        unique case (state_q)
            S_IDLE: begin
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    idx_d   = '0;
`ifdef NONCE_SYNC_EN
                    state_d = S_SYNC;
`else
                    state_d = S_SEND;
`endif
                end
            end
            S_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = 8'hA5;
                if (tx_ready) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = shift_q[7:0];
                if (tx_ready) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_IDLE;
                    end else begin
                        shift_d = {8'h00, shift_q[63:8]};
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flush abandons any partial frame and the queued results.
        if (flush) begin
            state_d = S_IDLE;
            pop     = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
            if (nonce_bus_wr && (cnt_q == FULL)) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q] <= nonce_bus;
        end
    end

    assign count    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_nonce_collector.sv
// tb_nonce_collector: directed-vector bench for nonce_collector.
// Drives inputs 1ns after each rising edge and samples outputs there too.
module tb_nonce_collector;

    logic        clk;
    logic        rst;
    logic [63:0] nonce_bus;
    logic        nonce_bus_wr;
    logic        flush;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  count;
    logic        overflow;

    int n_tests;
    int n_fail;

`ifdef NONCE_SYNC_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    nonce_collector #(.DEPTH(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .nonce_bus   (nonce_bus),
        .nonce_bus_wr(nonce_bus_wr),
        .flush       (flush),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .count       (count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input logic [63:0] n,
                                            input int i);
        int k;
        k = i;
`ifdef NONCE_SYNC_EN
        if (k == 0) return 8'hA5;
        k = k - 1;
`endif
        return n[8*k +: 8];
    endfunction

    task automatic strobe(input logic [63:0] n);
        nonce_bus    = n;
        nonce_bus_wr = 1'b1;
        tick();
        nonce_bus_wr = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0 repeating.
    task automatic recv_frame(input logic [63:0] n, input int mode);
        int       got;
        int       cyc;
        int       ph;
        logic     stalled;
        logic     rdy;
        logic [7:0] held;
        got     = 0;
        cyc     = 0;
        ph      = 0;
        stalled = 1'b0;
        held    = 8'h00;
        while (got < FLEN && cyc < 200) begin
            if (stalled) begin
                chk("stall_valid", 64'(tx_valid), 64'd1);
                chk("stall_data", 64'(tx_data), 64'(held));
            end
            rdy      = (mode == 0) ? 1'b1 : ((ph % 3) == 0);
            tx_ready = rdy;
            stalled  = 1'b0;
            if (tx_valid) begin
                ph++;
                if (rdy) begin
                    chk("frame_byte", 64'(tx_data), 64'(exp_byte(n, got)));
                    got++;
                end else begin
                    stalled = 1'b1;
                    held    = tx_data;
                end
            end
            tick();
            cyc++;
        end
        tx_ready = 1'b0;
        chk("frame_len", 64'(got), 64'(FLEN));
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b0;
        nonce_bus    = '0;
        nonce_bus_wr = 1'b0;
        flush        = 1'b0;
        tx_ready     = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(tx_valid), 64'd0);
        chk("rst_data", 64'(tx_data), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b1;
        tick();

        // Single nonce, ready held high: back-to-back bytes.
        tx_ready = 1'b1;
        strobe(64'h0123456789ABCDEF);
        chk("t1_count1", 64'(count), 64'd1);
        chk("t1_valid_n1", 64'(tx_valid), 64'd0);
        tick();
        for (int i = 0; i < FLEN; i++) begin
            chk("t1_valid", 64'(tx_valid), 64'd1);
            chk("t1_byte", 64'(tx_data),
                64'(exp_byte(64'h0123456789ABCDEF, i)));
            tick();
        end
        chk("t1_valid_end", 64'(tx_valid), 64'd0);
        chk("t1_count0", 64'(count), 64'd0);
        chk("t1_ovf", 64'(overflow), 64'd0);
        tx_ready = 1'b0;

        // Backpressure during a frame.
        strobe(64'hFEDCBA9876543210);
        recv_frame(64'hFEDCBA9876543210, 1);
        chk("bp_valid_end", 64'(tx_valid), 64'd0);
        chk("bp_count", 64'(count), 64'd0);

        // Burst of 6 with sink stalled: 1 in shifter, 4 queued, 1 dropped.
        for (int k = 1; k <= 6; k++) begin
            strobe(64'(k));
        end
        chk("burst_count", 64'(count), 64'd4);
        chk("burst_ovf", 64'(overflow), 64'd1);
        chk("burst_valid", 64'(tx_valid), 64'd1);
        chk("burst_head", 64'(tx_data), 64'(exp_byte(64'd1, 0)));
        for (int k = 1; k <= 5; k++) begin
            recv_frame(64'(k), 0);
        end
        chk("burst_cnt0", 64'(count), 64'd0);
        chk("burst_ovf_sticky", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("burst_no6", 64'(tx_valid), 64'd0);
        end

        // Full FIFO while IDLE pops: strobe still dropped.
        do_flush();
        chk("fl_ovf_clr", 64'(overflow), 64'd0);
        chk("fl_count", 64'(count), 64'd0);
        for (int k = 0; k < 5; k++) begin
            strobe(64'h10 + 64'(k));
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_ovf0", 64'(overflow), 64'd0);
        tx_ready = 1'b1;
        for (int i = 0; i < FLEN; i++) begin
            tick();
        end
        chk("full_idle", 64'(tx_valid), 64'd0);
        chk("full_count4", 64'(count), 64'd4);
        tx_ready = 1'b0;
        strobe(64'h99);
        chk("fullpop_count", 64'(count), 64'd3);
        chk("fullpop_ovf", 64'(overflow), 64'd1);
        chk("fullpop_valid", 64'(tx_valid), 64'd1);
        chk("fullpop_head", 64'(tx_data), 64'(exp_byte(64'h11, 0)));

        // Flush mid-frame after 3 bytes with 2 queued.
        do_flush();
        for (int k = 0; k < 3; k++) begin
            strobe(64'h2000 + 64'(k));
        end
        chk("mf_count", 64'(count), 64'd2);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        tx_ready     = 1'b0;
        flush        = 1'b1;
        nonce_bus    = 64'hDEAD;
        nonce_bus_wr = 1'b1;
        tick();
        flush = 1'b0;
        chk("mf_valid", 64'(tx_valid), 64'd0);
        chk("mf_count0", 64'(count), 64'd0);
        chk("mf_ovf", 64'(overflow), 64'd0);
        strobe(64'hCAFEF00D55AA1234);
        chk("mf_count1", 64'(count), 64'd1);
        recv_frame(64'hCAFEF00D55AA1234, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mf_no_dead", 64'(tx_valid), 64'd0);
        end

`ifdef NONCE_SYNC_EN
        strobe(64'h1);
        recv_frame(64'h1, 0);
`endif

        // Reset mid-frame with overflow set.
        for (int k = 0; k < 6; k++) begin
            strobe(64'h300 + 64'(k));
        end
        tx_ready = 1'b1;
        tick();
        tick();
        chk("rm_valid_pre", 64'(tx_valid), 64'd1);
        rst = 1'b0;
        tick();
        chk("rm_valid", 64'(tx_valid), 64'd0);
        chk("rm_data", 64'(tx_data), 64'd0);
        chk("rm_count", 64'(count), 64'd0);
        chk("rm_ovf", 64'(overflow), 64'd0);
        rst = 1'b1;
        tick();
        tick();
        chk("rm_stay_idle", 64'(tx_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
